conv_psum_requant: RTL

//  Downstream stage of the low-bit conv3x3 core. Takes per-OC-lane slice-combined partial sums
//  (one per IC tile of IC2_LANES channels). Accumulates them over all IC tiles of an output pixel
//  on top of a per-lane bias. Requantizes the total (round-shift, optional ReLU, clamp) to
//  cfg_out_bits codes for the next layer's activation writer.

---
 rtl/conv_pkg.sv | 45 ++++
 rtl/conv_requant_lane.sv | 32 +++
 rtl/conv_psum_requant.sv | 130 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv3x3 psum/requant path.
// clamp_code() is also used by the activation writer.
package conv_pkg;

    localparam int CODE_W = 8;
    localparam int WIDE_W = 64;

    typedef enum logic [1:0] {ST_ACC, ST_QUANT, ST_OUT} psq_state_e;

    typedef struct packed {
        logic [15:0] groups;
        logic [4:0]  shift;
        logic        relu_en;
        logic [3:0]  out_bits;
    } psq_cfg_t;

    // Odd, zero or >8 widths fall back to 8-bit codes.
    function automatic logic [3:0] norm_bits(input logic [7:0] b);
        if (b == 8'd2 || b == 8'd4 || b == 8'd6 || b == 8'd8)
            return b[3:0];
        return 4'd8;
    endfunction

    function automatic logic [CODE_W-1:0] clamp_code(input logic signed [WIDE_W-1:0] r,
                                                     input logic relu_en,
                                                     input logic [3:0] bits);
        logic signed [WIDE_W-1:0] lo, hi, c, mask;
        if (relu_en) begin
            lo = '0;
            hi = (64'sd1 <<< bits) - 64'sd1;
        end else begin
            lo = -(64'sd1 <<< (bits - 4'd1));
            hi = (64'sd1 <<< (bits - 4'd1)) - 64'sd1;
        end
        if (r < lo)
            c = lo;
        else if (r > hi)
            c = hi;
        else
            c = r;
        mask = (64'sd1 <<< bits) - 64'sd1;
        return CODE_W'(c & mask);
    endfunction

endpackage

// File: rtl/conv_requant_lane.sv
// Single-lane requantizer: round-half-up shift, optional ReLU, clamp to out_bits code.
module conv_requant_lane
    import conv_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic [3:0]              out_bits,
    output logic [OUT_W-1:0]        q
);

    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    logic [CODE_W-1:0]     code;

    // One extra bit keeps acc + half-LSB from wrapping before the shift.
    always_comb begin
        wide = {acc[ACC_W-1], acc};
        rnd  = (ACC_W+1)'(1) << (shift - 5'd1);
        if (shift == 5'd0)
            r = wide;
        else
            r = (wide + rnd) >>> shift;
        code = clamp_code(WIDE_W'(r), relu_en, out_bits);
        q    = OUT_W'(code);
    end

endmodule

// File: rtl/conv_psum_requant.sv
// Accumulates per-lane psums over all IC tiles of a pixel on top of a bias,
// then requantizes every lane and hands the codes downstream.
module conv_psum_requant
    import conv_pkg::*;
#(
    parameter int OC2_LANES = 16,
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  cfg_ic_groups,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu_en,
    input  logic [7:0]                   cfg_out_bits,
    input  logic [OC2_LANES*ACC_W-1:0]   bias_in,
    input  logic [OC2_LANES*ACC_W-1:0]   psum_in,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    output logic [OC2_LANES*OUT_W-1:0]   q_out,
    output logic                         q_valid,
    input  logic                         q_ready,
    output logic                         busy,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    psq_state_e                state;
    logic [15:0]               grp_cnt;
    psq_cfg_t                  cfg_q;
    psq_cfg_t                  cfg_new;
    logic signed [ACC_W-1:0]   acc     [OC2_LANES];
    logic signed [ACC_W-1:0]   acc_nxt [OC2_LANES];
    logic [OC2_LANES-1:0]      lane_ovf;
    logic [OC2_LANES*OUT_W-1:0] q_nxt;
    logic                      beat;
    logic                      first;
    logic                      last;
    logic [15:0]               groups_eff;

    assign beat  = psum_valid & psum_ready;
    assign first = (grp_cnt == 16'd0);
    assign busy  = (state != ST_ACC) || (grp_cnt != 16'd0);

    always_comb begin
        cfg_new.groups   = (cfg_ic_groups == 16'd0) ? 16'd1 : cfg_ic_groups;
        cfg_new.shift    = cfg_shift;
        cfg_new.relu_en  = cfg_relu_en;
        cfg_new.out_bits = norm_bits(cfg_out_bits);
        // The first beat decides the tile count from the live cfg it is latching.
        groups_eff       = first ? cfg_new.groups : cfg_q.groups;
        last             = (grp_cnt == groups_eff - 16'd1);
    end

    always_comb begin
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] b;
        lane_ovf = '0;
        for (int unsigned i = 0; i < OC2_LANES; i++) begin
            a           = first ? bias_in[i*ACC_W +: ACC_W] : acc[i];
            b           = psum_in[i*ACC_W +: ACC_W];
            acc_nxt[i]  = a + b;
            lane_ovf[i] = (a[ACC_W-1] == b[ACC_W-1]) && (acc_nxt[i][ACC_W-1] != a[ACC_W-1]);
        end
    end

    for (genvar g = 0; g < OC2_LANES; g++) begin : g_lane
        conv_requant_lane #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .acc      (acc[g]),
            .shift    (cfg_q.shift),
            .relu_en  (cfg_q.relu_en),
            .out_bits (cfg_q.out_bits),
            .q        (q_nxt[g*OUT_W +: OUT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ACC;
            grp_cnt    <= '0;
            cfg_q      <= '0;
            q_out      <= '0;
            q_valid    <= 1'b0;
            psum_ready <= 1'b1;
            ovf_sticky <= 1'b0;
            for (int unsigned i = 0; i < OC2_LANES; i++)
                acc[i] <= '0;
        end else begin
            if (beat && (|lane_ovf))
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;

            case (state)
                ST_ACC: begin
                    if (beat) begin
                        for (int unsigned i = 0; i < OC2_LANES; i++)
                            acc[i] <= acc_nxt[i];
                        if (first)
                            cfg_q <= cfg_new;
                        if (last) begin
                            grp_cnt    <= '0;
                            state      <= ST_QUANT;
                            psum_ready <= 1'b0;
                        end else begin
                            grp_cnt <= grp_cnt + 16'd1;
                        end
                    end
                end
                ST_QUANT: begin
                    q_out   <= q_nxt;
                    q_valid <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (q_ready) begin
                        q_valid    <= 1'b0;
                        psum_ready <= 1'b1;
                        state      <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule
